// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32 pipeline: default widths, register-index
// width and the MEM-stage access FSM state encoding.
package pipeline_pkg;

  localparam int BIT_W_DEF  = 32;
  localparam int ADDR_W_DEF = 30;
  localparam int REG_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // A cache access finishes in the cycle the cache is no longer busy.
  function automatic logic access_done(input logic mem_op, input logic dcache_stall);
    return mem_op & ~dcache_stall;
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Tracks one data-cache access so it is issued exactly once, holding load data
// while the rest of the pipeline is stalled by another source.
module mem_access_fsm
  import pipeline_pkg::*;
#(
  parameter int BIT_W = BIT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memrd_i,
  input  logic             memwr_i,
  input  logic             stall_i,
  input  logic             dcache_stall_i,
  input  logic [BIT_W-1:0] dcache_rdata_i,
  output logic             dcache_ren_o,
  output logic             dcache_wen_o,
  output logic             mem_stall_o,
  output logic [BIT_W-1:0] load_data_o
);

  mem_state_e       state_q;
  logic [BIT_W-1:0] capture_q;
  logic             mem_op_s;
  logic             issue_s;

  assign mem_op_s = memrd_i | memwr_i;

  // Access-tracking state and captured read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      capture_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_BUSY: begin
          if (!mem_op_s) begin
            state_q <= ST_IDLE;
          end else if (dcache_stall_i) begin
            state_q <= ST_BUSY;
          end else if (stall_i) begin
            // Completed but the pipeline is held: park here so it is not re-issued.
            state_q   <= ST_DONE;
            capture_q <= dcache_rdata_i;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (stall_i) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Cache request, stall and load-data selection; reset forces requests off.
  always_comb begin
    issue_s      = rst_n & mem_op_s & (state_q != ST_DONE);
    dcache_ren_o = issue_s & memrd_i & ~memwr_i;
    dcache_wen_o = issue_s & memwr_i;
    mem_stall_o  = issue_s & ~access_done(mem_op_s, dcache_stall_i);
    if (state_q == ST_DONE) begin
      load_data_o = capture_q;
    end else begin
      load_data_o = dcache_rdata_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32 pipeline: data-cache handshake, write-back select
// and the MEM/WB pipeline register.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int BIT_W  = BIT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIT_W-1:0]  alu_result_in,
  input  logic [BIT_W-1:0]  mem_wdata_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [BIT_W-1:0]  PC_plus_4_in,
  input  logic              memrd_in,
  input  logic              memwr_in,
  input  logic              mem2reg_in,
  input  logic              regwr_in,
  input  logic              jump_in,
  input  logic              stall_in,
  output logic              dcache_ren,
  output logic              dcache_wen,
  output logic [ADDR_W-1:0] dcache_addr,
  output logic [BIT_W-1:0]  dcache_wdata,
  input  logic [BIT_W-1:0]  dcache_rdata,
  input  logic              dcache_stall,
  output logic              mem_stall,
  output logic [BIT_W-1:0]  wb_data,
  output logic [REG_W-1:0]  rd_out,
  output logic              regwr_out,
  output logic [BIT_W-1:0]  fwd_data_noblock,
  output logic [REG_W-1:0]  fwd_rd_noblock,
  output logic              fwd_regwr_noblock
);

  logic [BIT_W-1:0] load_data_s;
  logic [BIT_W-1:0] wb_sel_s;
  logic             freeze_s;
  logic [BIT_W-1:0] wb_data_q, wb_data_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic             regwr_q, regwr_d;

  mem_access_fsm #(.BIT_W(BIT_W)) u_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .memrd_i        (memrd_in),
    .memwr_i        (memwr_in),
    .stall_i        (stall_in),
    .dcache_stall_i (dcache_stall),
    .dcache_rdata_i (dcache_rdata),
    .dcache_ren_o   (dcache_ren),
    .dcache_wen_o   (dcache_wen),
    .mem_stall_o    (mem_stall),
    .load_data_o    (load_data_s)
  );

  // Byte address bits [1:0] are dropped: only word accesses exist.
  assign dcache_addr  = alu_result_in[BIT_W-1:2];
  assign dcache_wdata = mem_wdata_in;

  // Write-back select (load data over link value over ALU) and MEM/WB next state.
  always_comb begin
    if (mem2reg_in) begin
      wb_sel_s = load_data_s;
    end else if (jump_in) begin
      wb_sel_s = PC_plus_4_in;
    end else begin
      wb_sel_s = alu_result_in;
    end
    freeze_s = stall_in | mem_stall;
    if (freeze_s) begin
      wb_data_d = wb_data_q;
      rd_d      = rd_q;
      regwr_d   = regwr_q;
    end else begin
      wb_data_d = wb_sel_s;
      rd_d      = rd_in;
      regwr_d   = regwr_in;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_data_q <= '0;
      rd_q      <= '0;
      regwr_q   <= 1'b0;
    end else begin
      wb_data_q <= wb_data_d;
      rd_q      <= rd_d;
      regwr_q   <= regwr_d;
    end
  end

  assign wb_data           = wb_data_q;
  assign rd_out            = rd_q;
  assign regwr_out         = regwr_q;
  assign fwd_data_noblock  = wb_sel_s;
  assign fwd_rd_noblock    = rd_in;
  assign fwd_regwr_noblock = regwr_in;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_result_in, mem_wdata_in, PC_plus_4_in, dcache_rdata;
  logic [4:0]  rd_in;
  logic        memrd_in, memwr_in, mem2reg_in, regwr_in, jump_in, stall_in, dcache_stall;
  logic        dcache_ren, dcache_wen, mem_stall, regwr_out, fwd_regwr_noblock;
  logic [29:0] dcache_addr;
  logic [31:0] dcache_wdata, wb_data, fwd_data_noblock;
  logic [4:0]  rd_out, fwd_rd_noblock;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .alu_result_in(alu_result_in), .mem_wdata_in(mem_wdata_in),
    .rd_in(rd_in), .PC_plus_4_in(PC_plus_4_in), .memrd_in(memrd_in), .memwr_in(memwr_in),
    .mem2reg_in(mem2reg_in), .regwr_in(regwr_in), .jump_in(jump_in), .stall_in(stall_in),
    .dcache_ren(dcache_ren), .dcache_wen(dcache_wen), .dcache_addr(dcache_addr),
    .dcache_wdata(dcache_wdata), .dcache_rdata(dcache_rdata), .dcache_stall(dcache_stall),
    .mem_stall(mem_stall), .wb_data(wb_data), .rd_out(rd_out), .regwr_out(regwr_out),
    .fwd_data_noblock(fwd_data_noblock), .fwd_rd_noblock(fwd_rd_noblock),
    .fwd_regwr_noblock(fwd_regwr_noblock)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    memrd_in = 1'b0; memwr_in = 1'b0; mem2reg_in = 1'b0; regwr_in = 1'b0;
    jump_in = 1'b0; stall_in = 1'b0; dcache_stall = 1'b0;
    alu_result_in = 32'h0; mem_wdata_in = 32'h0; PC_plus_4_in = 32'h0;
    dcache_rdata = 32'h0; rd_in = 5'd0;
  endtask

  initial begin
    set_nop();
    rst_n = 1'b0;
    // Reset gating: requests held off even with a pending load and busy cache.
    memrd_in = 1'b1; dcache_stall = 1'b1;
    #1;
    check("rst_ren", {31'b0, dcache_ren}, 32'd0);
    check("rst_stall", {31'b0, mem_stall}, 32'd0);
    next_cycle();
    check("rst_wb", wb_data, 32'h0);
    check("rst_rd", {27'b0, rd_out}, 32'd0);
    check("rst_regwr", {31'b0, regwr_out}, 32'd0);
    set_nop();
    next_cycle();
    rst_n = 1'b1;

    // 1: ALU op
    next_cycle();
    alu_result_in = 32'h0000_1234; regwr_in = 1'b1; rd_in = 5'd5; #1;
    check("alu_ren", {31'b0, dcache_ren}, 32'd0);
    check("alu_wen", {31'b0, dcache_wen}, 32'd0);
    check("alu_fwd", fwd_data_noblock, 32'h1234);
    check("alu_fwd_rd", {27'b0, fwd_rd_noblock}, 32'd5);

    // 2: load hit
    next_cycle();
    check("alu_wb", wb_data, 32'h1234);
    check("alu_rd", {27'b0, rd_out}, 32'd5);
    check("alu_regwr", {31'b0, regwr_out}, 32'd1);
    memrd_in = 1'b1; mem2reg_in = 1'b1; regwr_in = 1'b1; rd_in = 5'd7;
    alu_result_in = 32'h0000_0010; dcache_rdata = 32'hDEAD_BEEF; #1;
    check("hit_addr", {2'b0, dcache_addr}, 32'h4);
    check("hit_ren", {31'b0, dcache_ren}, 32'd1);
    check("hit_mstall", {31'b0, mem_stall}, 32'd0);

    // 3: load miss, three busy cycles
    next_cycle();
    check("hit_wb", wb_data, 32'hDEAD_BEEF);
    check("hit_rd", {27'b0, rd_out}, 32'd7);
    rd_in = 5'd9; alu_result_in = 32'h0000_0020; dcache_rdata = 32'h1111_1111; dcache_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) next_cycle();
      #1;
      check("miss_ren", {31'b0, dcache_ren}, 32'd1);
      check("miss_mstall", {31'b0, mem_stall}, 32'd1);
      check("miss_hold", wb_data, 32'hDEAD_BEEF);
    end
    next_cycle();
    dcache_stall = 1'b0; dcache_rdata = 32'h1234_5678; #1;
    check("miss_ren4", {31'b0, dcache_ren}, 32'd1);
    check("miss_mstall4", {31'b0, mem_stall}, 32'd0);

    // 4: store hit with stall_in held four cycles
    next_cycle();
    check("miss_wb", wb_data, 32'h1234_5678);
    check("miss_rd", {27'b0, rd_out}, 32'd9);
    memrd_in = 1'b0; mem2reg_in = 1'b0; regwr_in = 1'b0; memwr_in = 1'b1; rd_in = 5'd3;
    alu_result_in = 32'h0000_0040; mem_wdata_in = 32'hCAFE_0001; stall_in = 1'b1; #1;
    check("st_wen", {31'b0, dcache_wen}, 32'd1);
    check("st_wdata", dcache_wdata, 32'hCAFE_0001);
    check("st_addr", {2'b0, dcache_addr}, 32'h10);
    check("st_mstall", {31'b0, mem_stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("st_no_rewrite", {31'b0, dcache_wen}, 32'd0);
      check("st_hold", wb_data, 32'h1234_5678);
    end
    next_cycle();
    stall_in = 1'b0; #1;
    check("st_release_wen", {31'b0, dcache_wen}, 32'd0);

    // 5: load completes under stall_in, then rdata changes
    next_cycle();
    check("st_regwr", {31'b0, regwr_out}, 32'd0);
    check("st_rd", {27'b0, rd_out}, 32'd3);
    memwr_in = 1'b0; memrd_in = 1'b1; mem2reg_in = 1'b1; regwr_in = 1'b1; rd_in = 5'd12;
    alu_result_in = 32'h0000_0080; dcache_rdata = 32'hA5A5_5A5A; stall_in = 1'b1; #1;
    check("cap_ren", {31'b0, dcache_ren}, 32'd1);
    check("cap_fwd", fwd_data_noblock, 32'hA5A5_5A5A);
    next_cycle();
    dcache_rdata = 32'h0; #1;
    check("cap_ren_done", {31'b0, dcache_ren}, 32'd0);
    check("cap_fwd_held", fwd_data_noblock, 32'hA5A5_5A5A);
    next_cycle();
    stall_in = 1'b0; #1;
    check("cap_fwd_rel", fwd_data_noblock, 32'hA5A5_5A5A);

    // 6: jal, then reset during a BUSY load
    next_cycle();
    check("cap_wb", wb_data, 32'hA5A5_5A5A);
    check("cap_rd", {27'b0, rd_out}, 32'd12);
    check("cap_regwr", {31'b0, regwr_out}, 32'd1);
    memrd_in = 1'b0; mem2reg_in = 1'b0; jump_in = 1'b1; PC_plus_4_in = 32'h0000_0104;
    rd_in = 5'd1; regwr_in = 1'b1; alu_result_in = 32'h0000_FFFF; #1;
    check("jal_fwd", fwd_data_noblock, 32'h104);
    next_cycle();
    check("jal_wb", wb_data, 32'h104);
    check("jal_rd", {27'b0, rd_out}, 32'd1);
    memrd_in = 1'b1; mem2reg_in = 1'b1; rd_in = 5'd2; alu_result_in = 32'h0000_0100;
    dcache_stall = 1'b1; dcache_rdata = 32'h0000_0077; #1;
    check("prio_fwd", fwd_data_noblock, 32'h77);
    check("busy_mstall", {31'b0, mem_stall}, 32'd1);
    next_cycle();
    rst_n = 1'b0; #1;
    check("rstbusy_ren", {31'b0, dcache_ren}, 32'd0);
    check("rstbusy_mstall", {31'b0, mem_stall}, 32'd0);
    check("rstbusy_wb_held", wb_data, 32'h104);
    next_cycle();
    rst_n = 1'b1; set_nop(); #1;
    check("post_rst_wb", wb_data, 32'h0);
    check("post_rst_rd", {27'b0, rd_out}, 32'd0);
    check("post_rst_regwr", {31'b0, regwr_out}, 32'd0);
    check("post_rst_ren", {31'b0, dcache_ren}, 32'd0);

    // Both load and store asserted: treated as a store, FSM back in IDLE.
    next_cycle();
    memrd_in = 1'b1; memwr_in = 1'b1; #1;
    check("both_ren", {31'b0, dcache_ren}, 32'd0);
    check("both_wen", {31'b0, dcache_wen}, 32'd1);
    next_cycle();
    set_nop();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
